pipe_hazard_unit: RTL

Parametrised forwarding and hazard-control unit for the 5-stage RISC-V pipeline. It tracks in-flight destination registers for EX, MEM and WB in its own slot registers, and drives operand-forwarding selects for NRD read ports. It generates load-use stalls, taken-branch flushes and data-memory wait-state freezes, and keeps saturating stall/flush performance counters. It sits beside the ID/EX pipeline registers and replaces ad-hoc forwarding logic in the core top level.

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/hz_sat_counter.sv | 32 +++
 rtl/pipe_hazard_unit.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared pipeline types for the hazard/forwarding block.
// Slot geometry follows the core's fixed read-port count and register width.
package cpu_pkg;

  localparam int unsigned CPU_NRD  = 2;
  localparam int unsigned CPU_REGW = 5;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

  typedef struct packed {
    logic                                valid;
    logic [CPU_REGW-1:0]                 rd;
    logic                                wr_en;
    logic                                is_load;
    logic [CPU_NRD-1:0][CPU_REGW-1:0]    rs;
    logic [CPU_NRD-1:0]                  rs_used;
  } hz_slot_t;

  // A slot that will really write a non-x0 register.
  function automatic logic slot_live(hz_slot_t s);
    return s.valid && s.wr_en && (s.rd != '0);
  endfunction

endpackage

// File: rtl/hz_sat_counter.sv
// Saturating up-counter for pipeline performance events.
// Sticks at all-ones instead of wrapping.
module hz_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_unit.sv
// Forwarding selects, load-use stalls, branch flushes and memory freezes
// for the 5-stage pipeline, tracked with private EX/MEM/WB slots.
module pipe_hazard_unit
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NRD   = CPU_NRD,
  parameter int unsigned REGW  = CPU_REGW,
  parameter int unsigned CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid_i,
  input  logic [NRD*REGW-1:0] id_rs_i,
  input  logic [NRD-1:0]      id_rs_used_i,
  input  logic [REGW-1:0]     id_rd_i,
  input  logic                id_wr_en_i,
  input  logic                id_is_load_i,
  input  logic                ex_branch_taken_i,
  input  logic                mem_req_i,
  input  logic                mem_ready_i,
  output logic                stall_if_o,
  output logic                stall_id_o,
  output logic                flush_id_o,
  output logic                freeze_o,
  output logic [2*NRD-1:0]    fwd_sel_o,
  output logic [CNT_W-1:0]    perf_stall_cnt_o,
  output logic [CNT_W-1:0]    perf_flush_cnt_o
);

  if ((NRD != CPU_NRD) || (REGW != CPU_REGW)) begin : g_bad_geom
    $error("pipe_hazard_unit: NRD/REGW must match cpu_pkg slot geometry");
  end

  if ((CNT_W == 0) || (CNT_W > XLEN)) begin : g_bad_cnt
    $error("pipe_hazard_unit: CNT_W must be in 1..XLEN");
  end

  hz_slot_t ex_q, ex_d;
  hz_slot_t mem_q, mem_d;
  hz_slot_t wb_q, wb_d;
  hz_slot_t id_slot;

  logic freeze;
  logic flush;
  logic lu_hit;
  logic load_use;

  fwd_sel_e [NRD-1:0] fwd_sel;

  always_comb begin
    id_slot         = '0;
    id_slot.valid   = id_valid_i;
    id_slot.rd      = id_rd_i;
    id_slot.wr_en   = id_wr_en_i;
    id_slot.is_load = id_is_load_i;
    id_slot.rs      = id_rs_i;
    id_slot.rs_used = id_rs_used_i;
  end

  // Reset gates freeze so every output is quiet while rst_n is low.
  assign freeze = rst_n && mem_req_i && !mem_ready_i;
  assign flush  = ex_q.valid && ex_branch_taken_i && !freeze;

  always_comb begin
    lu_hit = 1'b0;
    for (int p = 0; p < NRD; p++) begin
      if (id_valid_i && id_slot.rs_used[p] &&
          (id_slot.rs[p] == ex_q.rd)) begin
        lu_hit = 1'b1;
      end
    end
    lu_hit = lu_hit && ex_q.is_load && slot_live(ex_q);
  end

  assign load_use = lu_hit && !freeze && !flush;

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (!freeze) begin
      mem_d = ex_q;
      wb_d  = mem_q;
      if (flush || load_use) begin
        ex_d = '0;
      end else begin
        ex_d = id_slot;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  // MEM wins over WB so the youngest producer is forwarded.
  always_comb begin
    for (int p = 0; p < NRD; p++) begin
      fwd_sel[p] = FWD_RF;
      if (ex_q.rs_used[p]) begin
        if (slot_live(mem_q) && !mem_q.is_load &&
            (mem_q.rd == ex_q.rs[p])) begin
          fwd_sel[p] = FWD_MEM;
        end else if (slot_live(wb_q) &&
                     (wb_q.rd == ex_q.rs[p])) begin
          fwd_sel[p] = FWD_WB;
        end
      end
    end
  end

  assign fwd_sel_o  = fwd_sel;
  assign stall_if_o = freeze || load_use;
  assign stall_id_o = freeze || load_use;
  assign flush_id_o = flush;
  assign freeze_o   = freeze;

  hz_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (stall_if_o),
    .cnt_o (perf_stall_cnt_o)
  );

  hz_sat_counter #(
    .CNT_W (CNT_W)
  ) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (flush_id_o),
    .cnt_o (perf_flush_cnt_o)
  );

  logic unused_slot;
  assign unused_slot = ^{mem_q.rs, mem_q.rs_used,
                         wb_q.rs, wb_q.rs_used, wb_q.is_load};

endmodule
